// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its two-port arbiter: op codes,
// FSM state encoding and the legal-op check.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  function automatic logic is_legal_op(input logic [3:0] sel);
    logic legal;
    case (sel)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB: legal = 1'b1;
      default:                           legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: AND/OR/ADD/SUB modulo 2^n; unknown op codes yield 0.
module alu
  import alu_pkg::*;
#(
  parameter int n = 32
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic [3:0]   sel,
  output logic [n-1:0] result,
  output logic         zero
);

  always_comb begin
    result = '0;
    case (sel)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      default: result = '0;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/alu_port_arbiter.sv
// Shares one ALU between two valid/ready requesters with a round-robin
// pointer and an IDLE -> EXEC -> RESP sequence per operation.
module alu_port_arbiter
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  input  logic         req1_valid,
  output logic         req0_ready,
  output logic         req1_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req0_b,
  input  logic [N-1:0] req1_b,
  input  logic [3:0]   req0_sel,
  input  logic [3:0]   req1_sel,
  output logic         rsp0_valid,
  output logic         rsp1_valid,
  input  logic         rsp0_ready,
  input  logic         rsp1_ready,
  output logic [N-1:0] rsp0_result,
  output logic [N-1:0] rsp1_result,
  output logic         rsp0_zero,
  output logic         rsp1_zero,
  output logic         rsp0_illegal,
  output logic         rsp1_illegal,
  output logic         busy
);

  logic [1:0]   state;
  logic         prio;
  logic         gnt;
  logic [N-1:0] a_q;
  logic [N-1:0] b_q;
  logic [3:0]   sel_q;
  logic [N-1:0] res_q;
  logic         zero_q;
  logic         illegal_q;
  logic [N-1:0] alu_result;
  logic         alu_zero;
  logic         win;
  logic         any_valid;
  logic         in_resp;
  logic         rsp_taken;

  alu #(.n(N)) u_alu (
    .a      (a_q),
    .b      (b_q),
    .sel    (sel_q),
    .result (alu_result),
    .zero   (alu_zero)
  );

  // Contention goes to prio; a lone request wins outright.
  assign any_valid = req0_valid | req1_valid;
  assign win       = (req0_valid && req1_valid) ? prio : req1_valid;

  assign req0_ready = (state == ST_IDLE) && req0_valid && !win;
  assign req1_ready = (state == ST_IDLE) && req1_valid && win;

  assign in_resp   = (state == ST_RESP);
  assign rsp_taken = gnt ? rsp1_ready : rsp0_ready;
  assign busy      = (state != ST_IDLE);

  assign rsp0_valid   = in_resp && !gnt;
  assign rsp1_valid   = in_resp && gnt;
  assign rsp0_result  = rsp0_valid ? res_q : '0;
  assign rsp1_result  = rsp1_valid ? res_q : '0;
  assign rsp0_zero    = rsp0_valid && zero_q;
  assign rsp1_zero    = rsp1_valid && zero_q;
  assign rsp0_illegal = rsp0_valid && illegal_q;
  assign rsp1_illegal = rsp1_valid && illegal_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      prio      <= 1'b0;
      gnt       <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      sel_q     <= '0;
      res_q     <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_valid) begin
            gnt   <= win;
            a_q   <= win ? req1_a : req0_a;
            b_q   <= win ? req1_b : req0_b;
            sel_q <= win ? req1_sel : req0_sel;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          res_q     <= alu_result;
          zero_q    <= alu_zero;
          illegal_q <= !is_legal_op(sel_q);
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_taken) begin
            prio  <= !gnt;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_port_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic, checked
// against a transaction-level model of the two-port ALU arbiter.
module tb_alu_port_arbiter;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  sel;
  } op_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req1_a = '0, req0_b = '0, req1_b = '0;
  logic [3:0]  req0_sel = '0, req1_sel = '0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [31:0] rsp0_result, rsp1_result;
  logic        rsp0_zero, rsp1_zero, rsp0_illegal, rsp1_illegal;
  logic        busy;

  int tests = 0;
  int fails = 0;

  op_t q0[$];
  op_t q1[$];
  int  grant_log[$];
  int  hold0 = 0, hold1 = 0;
  bit  rand_ready = 0;

  // Transaction-level reference state
  int          cyc = 0;
  bit          m_inflight = 0;
  int          m_gnt = 0, m_prio = 0, m_acc_cyc = 0;
  logic [31:0] m_res;
  bit          m_zero, m_ill;
  logic [31:0] last_res[2];
  bit          last_zero[2];
  bit          last_ill[2];

  alu_port_arbiter #(.N(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req1_a(req1_a), .req0_b(req0_b), .req1_b(req1_b),
    .req0_sel(req0_sel), .req1_sel(req1_sel),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .rsp0_result(rsp0_result), .rsp1_result(rsp1_result),
    .rsp0_zero(rsp0_zero), .rsp1_zero(rsp1_zero),
    .rsp0_illegal(rsp0_illegal), .rsp1_illegal(rsp1_illegal),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void ref_alu(input op_t op, output logic [31:0] r, output bit z, output bit il);
    il = 0;
    case (op.sel)
      4'b0000: r = op.a & op.b;
      4'b0001: r = op.a | op.b;
      4'b0010: r = op.a + op.b;
      4'b0110: r = op.a - op.b;
      default: begin r = 32'd0; il = 1; end
    endcase
    z = (r == 32'd0);
  endfunction

  function automatic op_t mk(input logic [31:0] a, input logic [31:0] b, input logic [3:0] sel);
    op_t o;
    o.a = a; o.b = b; o.sel = sel;
    return o;
  endfunction

  // One clock cycle: drive from the request queues, check, advance the model.
  task automatic apply_stimulus();
    bit v0, v1, r0, r1, e_v0, e_v1, e_rdy0, e_rdy1;
    int win;
    op_t op;
    v0 = (q0.size() > 0);
    v1 = (q1.size() > 0);
    req0_valid = v0;
    req1_valid = v1;
    if (v0) begin req0_a = q0[0].a; req0_b = q0[0].b; req0_sel = q0[0].sel; end
    else begin req0_a = $urandom; req0_b = $urandom; req0_sel = 4'($urandom); end
    if (v1) begin req1_a = q1[0].a; req1_b = q1[0].b; req1_sel = q1[0].sel; end
    else begin req1_a = $urandom; req1_b = $urandom; req1_sel = 4'($urandom); end
    e_v0 = m_inflight && (cyc >= m_acc_cyc + 2) && (m_gnt == 0);
    e_v1 = m_inflight && (cyc >= m_acc_cyc + 2) && (m_gnt == 1);
    r0 = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    r1 = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (e_v0 && hold0 > 0) begin r0 = 0; hold0--; end
    if (e_v1 && hold1 > 0) begin r1 = 0; hold1--; end
    rsp0_ready = r0;
    rsp1_ready = r1;
    #1;
    win = (v0 && v1) ? m_prio : (v1 ? 1 : 0);
    e_rdy0 = !m_inflight && v0 && (win == 0);
    e_rdy1 = !m_inflight && v1 && (win == 1);
    check_output("req0_ready", 32'(req0_ready), 32'(e_rdy0));
    check_output("req1_ready", 32'(req1_ready), 32'(e_rdy1));
    check_output("busy", 32'(busy), 32'(m_inflight));
    check_output("rsp0_valid", 32'(rsp0_valid), 32'(e_v0));
    check_output("rsp1_valid", 32'(rsp1_valid), 32'(e_v1));
    if (e_v0) begin
      check_output("rsp0_result", rsp0_result, m_res);
      check_output("rsp0_zero", 32'(rsp0_zero), 32'(m_zero));
      check_output("rsp0_illegal", 32'(rsp0_illegal), 32'(m_ill));
    end
    if (e_v1) begin
      check_output("rsp1_result", rsp1_result, m_res);
      check_output("rsp1_zero", 32'(rsp1_zero), 32'(m_zero));
      check_output("rsp1_illegal", 32'(rsp1_illegal), 32'(m_ill));
    end
    if (m_inflight && m_gnt == 1) begin
      check_output("rsp0_idle_outputs", {rsp0_result[29:0], rsp0_zero, rsp0_illegal}, 32'd0);
      check_output("rsp0_idle_msbs", 32'(rsp0_result[31:30]), 32'd0);
    end
    if (m_inflight && m_gnt == 0) begin
      check_output("rsp1_idle_outputs", {rsp1_result[29:0], rsp1_zero, rsp1_illegal}, 32'd0);
      check_output("rsp1_idle_msbs", 32'(rsp1_result[31:30]), 32'd0);
    end
    if (!m_inflight && (v0 || v1)) begin
      op = (win == 1) ? q1.pop_front() : q0.pop_front();
      ref_alu(op, m_res, m_zero, m_ill);
      m_inflight = 1;
      m_gnt = win;
      m_acc_cyc = cyc;
      grant_log.push_back(win);
    end else if ((e_v0 && r0) || (e_v1 && r1)) begin
      last_res[m_gnt] = m_res;
      last_zero[m_gnt] = m_zero;
      last_ill[m_gnt] = m_ill;
      m_inflight = 0;
      m_prio = 1 - m_gnt;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_until_done(input string tag);
    int budget = 400;
    while ((q0.size() > 0 || q1.size() > 0 || m_inflight) && budget > 0) begin
      apply_stimulus();
      budget--;
    end
    if (budget == 0) check_output({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  // Asserts reset mid-cycle and checks outputs clear without waiting for a clock edge.
  task automatic apply_reset();
    q0.delete(); q1.delete();
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    rst_n = 0;
    #1;
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    check_output("rst_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    check_output("rst_result0", rsp0_result, 32'd0);
    check_output("rst_result1", rsp1_result, 32'd0);
    check_output("rst_flags", {28'd0, rsp1_zero, rsp1_illegal, rsp0_zero, rsp0_illegal}, 32'd0);
    m_inflight = 0; m_prio = 0; m_gnt = 0;
    hold0 = 0; hold1 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    apply_reset();

    q0.push_back(mk(32'd5, 32'd7, 4'b0010));
    run_until_done("add");
    check_output("add_result", last_res[0], 32'd12);
    check_output("add_zero", 32'(last_zero[0]), 32'd0);
    check_output("add_illegal", 32'(last_ill[0]), 32'd0);

    q1.push_back(mk(32'd9, 32'd9, 4'b0110));
    run_until_done("sub_eq");
    check_output("sub_eq_result", last_res[1], 32'd0);
    check_output("sub_eq_zero", 32'(last_zero[1]), 32'd1);
    q1.push_back(mk(32'd3, 32'd5, 4'b0110));
    run_until_done("sub_neg");
    check_output("sub_neg_result", last_res[1], 32'hFFFF_FFFE);
    check_output("sub_neg_zero", 32'(last_zero[1]), 32'd0);

    apply_reset();
    grant_log.delete();
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk($urandom, $urandom, 4'b0010));
      q1.push_back(mk($urandom, $urandom, 4'b0000));
    end
    run_until_done("alternate");
    for (int i = 0; i < 8; i++)
      check_output($sformatf("alt_grant%0d", i), 32'(grant_log[i]), 32'(i % 2));

    grant_log.delete();
    q0.push_back(mk(32'hF0F0_0000, 32'h0000_0F0F, 4'b0001));
    q0.push_back(mk(32'd1, 32'd2, 4'b0010));
    q1.push_back(mk(32'd10, 32'd4, 4'b0110));
    hold0 = 4;
    run_until_done("backpressure");
    check_output("bp_grant0", 32'(grant_log[0]), 32'd0);
    check_output("bp_grant1", 32'(grant_log[1]), 32'd1);
    check_output("bp_grant2", 32'(grant_log[2]), 32'd0);
    check_output("bp_result1", last_res[1], 32'd6);

    q0.push_back(mk(32'd1, 32'd1, 4'b0111));
    run_until_done("illegal");
    check_output("ill_result", last_res[0], 32'd0);
    check_output("ill_zero", 32'(last_zero[0]), 32'd1);
    check_output("ill_flag", 32'(last_ill[0]), 32'd1);
    q0.push_back(mk(32'd6, 32'd3, 4'b0000));
    run_until_done("legal_after");
    check_output("legal_after_result", last_res[0], 32'd2);
    check_output("legal_after_illegal", 32'(last_ill[0]), 32'd0);

    q0.push_back(mk(32'd20, 32'd22, 4'b0010));
    apply_stimulus();
    check_output("exec_busy", 32'(busy), 32'd1);
    apply_reset();
    q1.push_back(mk(32'd100, 32'd1, 4'b0110));
    run_until_done("after_reset");
    check_output("after_reset_result", last_res[1], 32'd99);

    rand_ready = 1;
    for (int i = 0; i < 400; i++) begin
      if (q0.size() == 0 && $urandom_range(0, 2) == 0)
        q0.push_back(mk($urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom, 4'($urandom_range(0, 7))));
      if (q1.size() == 0 && $urandom_range(0, 2) == 0)
        q1.push_back(mk($urandom, $urandom, 4'($urandom_range(0, 7))));
      apply_stimulus();
    end
    rand_ready = 0;
    run_until_done("random_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_port_arbiter.md
# alu_port_arbiter

Shares a single `alu` instance between two requesters (e.g. integer pipe and address/branch helper) using valid/ready handshakes on both request and response sides. A round-robin grant pointer and a three-state FSM serialise operations: the winning request's operands are latched, the ALU is evaluated, and the registered result is held until the requester accepts it. The block sits between the requesters and the ALU and is the only driver of the ALU's inputs.

## Interface
- `N`, 32, operand/result width; passed to the ALU as `n`.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0_valid`, `req1_valid`  in  1  request present on port 0/1.
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle.
- `req0_a`, `req1_a`, `req0_b`, `req1_b`  in  N  operands.
- `req0_sel`, `req1_sel`  in  4  ALU op code.
- `rsp0_valid`, `rsp1_valid`  out  1  response available on port 0/1.
- `rsp0_ready`, `rsp1_ready`  in  1  requester takes the response.
- `rsp0_result`, `rsp1_result`  out  N  registered ALU result.
- `rsp0_zero`, `rsp1_zero`  out  1  registered zero flag.
- `rsp0_illegal`, `rsp1_illegal`  out  1  op code was not AND/OR/ADD/SUB.
- `busy`  out  1  FSM is not in IDLE.

## Operation
- Op codes: AND `4'b0000`, OR `4'b0001`, ADD `4'b0010`, SUB `4'b0110`. Any other code is illegal: result 0, zero 1, illegal 1.
- FSM states: IDLE, EXEC, RESP.
- IDLE: compute the grant combinationally. If both valids are high, port `prio` wins; if only one is high, that port wins. Assert `reqX_ready` for the winner only. On the edge, latch a/b/sel and the granted port id, then go to EXEC. With no valid, stay in IDLE.
- EXEC: the ALU sees the latched operands. On the edge, register result, zero and illegal, then go to RESP.
- RESP: assert `rspX_valid` only on the granted port. Result, zero and illegal stay stable while waiting. On the edge where `rspX_ready` is high, go to IDLE and set `prio` to the non-granted port.
- `req*_ready` is low outside IDLE, so no request is accepted while an operation is in flight.
- `rsp*_ready` is ignored when the matching `rsp*_valid` is low.
- `rsp*_result`, `rsp*_zero` and `rsp*_illegal` on the non-granted port are driven 0.
- Arithmetic is modulo 2^N; carry and overflow are discarded.

## Timing
- Reset values (asynchronous, immediate): state IDLE, `prio` 0, all ready/valid/result/zero/illegal outputs 0, `busy` 0.
- Reset mid-operation aborts the operation. The pending response is lost and the requester must reissue.
- Latency: request accepted at edge 0, `rsp_valid` high after edge 2. If the response is taken in the same cycle it appears, the next request can be accepted at edge 3.
- Throughput: at most one operation per 3 cycles.
- `req*_ready` depends combinationally on `req*_valid`, `state` and `prio`. Requesters must not make `valid` depend on `ready`.
- A requester holds its request stable while `valid` is high and `ready` is low.

## Structure
- Package `alu_pkg` holds:
  - op-code constants `ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_SUB`;
  - the FSM state encoding (`ST_IDLE`, `ST_EXEC`, `ST_RESP`);
  - the legal-op check function.
- One sub-module: the existing `alu` (parameter `n = N`), instantiated once and fed from the latched operand registers.
- The arbiter logic (grant, pointer, FSM, response registers) stays in this module.

## Test plan
- Reset: assert `rst_n` low during EXEC → all outputs 0 immediately, `busy` 0. After release, a new request on port 1 is granted normally.
- Port 0 ADD, a=5, b=7 → `req0_ready` high in cycle 0; `rsp0_valid` high after edge 2 with result 12, zero 0, illegal 0; port 1 outputs stay 0.
- Port 1 SUB 9−9 → result 0, zero 1. Port 1 SUB 3−5 → result `32'hFFFFFFFE`, zero 0.
- Both valids held high continuously with immediate `rsp_ready` → grants alternate 0,1,0,1, starting with port 0 after reset.
- Backpressure: `rsp0_ready` held low for 4 cycles → `rsp0_valid` and result stay stable; `req1_ready` stays low despite `req1_valid`. Port 1 is granted in the first IDLE cycle after port 0's response is taken.
- Illegal sel `4'b0111`, a=1, b=1 → result 0, zero 1, illegal 1. The next legal op clears illegal.
